// File: rtl/flash_arbiter.sv
`default_nettype none
// ============================================================================
// flash_arbiter : round-robin arbiter for two requesters sharing one flash_serial engine
// Revision 1.0
// ============================================================================
module flash_arbiter #(
  parameter int WORD_BITS     = 8,
  parameter int ADDRESS_WORDS = 2,
  parameter int GAP_CYCLES    = 4,
  parameter int TIMEOUT       = 4096
) (
  input  logic                                   in_clk,
  input  logic                                   in_rst,
  input  logic [1:0]                             in_req,
  input  logic [1:0]                             in_read,
  input  logic [2*WORD_BITS*ADDRESS_WORDS-1:0]   in_addr,
  input  logic [2*WORD_BITS*ADDRESS_WORDS-1:0]   in_len,
  input  logic [2*WORD_BITS-1:0]                 in_wdata,
  output logic [1:0]                             out_grant,
  output logic [WORD_BITS-1:0]                   out_rdata,
  output logic [1:0]                             out_rvalid,
  output logic [1:0]                             out_wack,
  output logic [1:0]                             out_done,
  output logic                                   out_err,
  output logic                                   out_flash_rst,
  output logic                                   out_flash_enable,
  output logic                                   out_flash_read,
  output logic [WORD_BITS*ADDRESS_WORDS-1:0]     out_flash_addr,
  output logic [WORD_BITS-1:0]                   out_flash_wdata,
  input  logic [WORD_BITS-1:0]                   in_flash_rdata,
  input  logic                                   in_flash_word_finished
);
  localparam int AW = WORD_BITS * ADDRESS_WORDS;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  logic [1:0]           state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 prio_q, prio_d;
  logic [1:0]           grant_q, grant_d;
  logic                 read_q, read_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [AW-1:0]        len_q, len_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [WORD_BITS-1:0] rdata_q, rdata_d;
  logic [1:0]           rvalid_q, rvalid_d;
  logic [1:0]           wack_q, wack_d;
  logic                 err_q, err_d;
  logic                 wf_prev_q;
  logic                 rst_d1_q;
  logic                 flash_rst_q;

  logic                 winner;
  logic [AW-1:0]        win_len;
  logic                 word_evt;
  logic                 last_word;
  logic                 tmo_hit;

  // With both requesting, the requester not served last holds priority.
  assign winner    = (&in_req) ? prio_q : in_req[1];
  assign win_len   = winner ? in_len[AW +: AW] : in_len[0 +: AW];
  assign word_evt  = (state_q == ST_RUN) && in_flash_word_finished && !wf_prev_q;
  assign last_word = (cnt_q == (len_q - AW'(1)));
  assign tmo_hit   = (state_q == ST_RUN) && !word_evt && (tmo_q == TMO_LAST);

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|in_req) state_d = ST_RUN;
      ST_RUN:  if ((word_evt && last_word) || tmo_hit) state_d = ST_GAP;
      ST_GAP:  if (gap_q == GAP_LAST) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    owner_d  = owner_q;
    prio_d   = prio_q;
    grant_d  = grant_q;
    read_d   = read_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    tmo_d    = '0;
    gap_d    = '0;
    rdata_d  = rdata_q;
    rvalid_d = 2'b00;
    wack_d   = 2'b00;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (|in_req) begin
          owner_d = winner;
          prio_d  = ~winner;
          grant_d = winner ? 2'b10 : 2'b01;
          read_d  = in_read[winner];
          addr_d  = winner ? in_addr[AW +: AW] : in_addr[0 +: AW];
          len_d   = (win_len == '0) ? AW'(1) : win_len;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (word_evt) begin
          cnt_d = cnt_q + AW'(1);
          if (read_q) begin
            rdata_d  = in_flash_rdata;
            rvalid_d = grant_q;
          end else begin
            wack_d = grant_q;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (tmo_hit) err_d = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          grant_d = 2'b00;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      owner_q  <= 1'b0;
      prio_q   <= 1'b0;
      grant_q  <= 2'b00;
      read_q   <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      gap_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 2'b00;
      wack_q   <= 2'b00;
      err_q    <= 1'b0;
      wf_prev_q <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      prio_q   <= prio_d;
      grant_q  <= grant_d;
      read_q   <= read_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      gap_q    <= gap_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      wack_q   <= wack_d;
      err_q    <= err_d;
      wf_prev_q <= in_flash_word_finished;
    end
  end

  // Flash reset covers every reset cycle plus one cycle after release.
  always_ff @(posedge in_clk) begin
    rst_d1_q    <= in_rst;
    flash_rst_q <= in_rst | rst_d1_q;
  end

  always_comb begin
    out_flash_enable = (state_q == ST_RUN);
    out_done         = ((state_q == ST_GAP) && (gap_q == GAP_LAST)) ? grant_q : 2'b00;
    out_flash_wdata  = owner_q ? in_wdata[WORD_BITS +: WORD_BITS] : in_wdata[0 +: WORD_BITS];
  end

  assign out_grant      = grant_q;
  assign out_rdata      = rdata_q;
  assign out_rvalid     = rvalid_q;
  assign out_wack       = wack_q;
  assign out_err        = err_q;
  assign out_flash_rst  = flash_rst_q;
  assign out_flash_read = read_q;
  assign out_flash_addr = addr_q;

endmodule
`default_nettype wire
